zbritesi_24bit_seq: RTL
=======================

# zbritesi_24bit_seq

- Sequential 24-bit subtractor; the inverse-direction companion to the team's 24-bit ripple adder.
- Computes `a - b` a few bits per clock using a registered borrow chain, so the datapath stays narrow.
- Uses a start/busy/done handshake and reports borrow and status flags.
- Sits beside the adder in the CPU ALU for SUB/CMP operations whose timing is not on the critical path.

## Interface
- `WIDTH`, default 24: operand width. Only 24 is supported.
- `STEP`, default 1: bits processed per cycle. Must divide `WIDTH` (1, 2, 3, 4, 6, 8, 12 or 24). `N = WIDTH/STEP`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request. Sampled only when `busy=0`.
- `a` input 24: minuend. Sampled with an accepted `start`.
- `b` input 24: subtrahend. Sampled with an accepted `start`.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; results valid.
- `diff` output 24: `a - b` mod 2^24.
- `borrowout` output 1: 1 when `a < b` (unsigned).
- `zero` output 1: `diff == 0`.
- `negative` output 1: `diff[23]`.
- `overflow` output 1: signed overflow of `a - b`.

## Operation
- FSM has two states: IDLE and RUN.
- **Accept:** `start=1` while `busy=0` moves the FSM to RUN and:
  - latches `a` and `b` into shift registers;
  - clears the internal borrow register to 0;
  - clears the slice counter to 0.
- **RUN, each cycle:**
  - low `STEP` bits: `{borrow_next, slice} = a_slice - b_slice - borrow`;
  - the result slice shifts into the result register from the MSB side;
  - the operand registers shift right by `STEP`;
  - the counter increments.
- **Completion:** on the cycle the counter reaches `N-1`, the next edge:
  - loads `diff`, `borrowout` (final borrow) and the flags into the output registers;
  - pulses `done` and clears `busy`;
  - returns the FSM to IDLE.
- **Flag rules:**
  - `overflow = (a[23] != b[23]) && (diff[23] != a[23])`, using latched operands;
  - `borrowout` is the unsigned borrow out of bit 23.
- Outputs hold their value until the next completion. They do not change while a new operation runs.
- `start` while `busy=1` is ignored. Inputs `a` and `b` are don't-care after acceptance.
- Reset values (asynchronous, in any state, including mid-operation):
  - FSM in IDLE;
  - `busy=0`, `done=0`, `diff=0`, `borrowout=0`, `zero=0`, `negative=0`, `overflow=0`;
  - the operation in progress is discarded and never signals `done`.

## Timing
- `start` is accepted at edge E0; `busy=1` from E0 to E0+N.
- At edge E0+N: results are registered, `done=1`, `busy=0`.
- At edge E0+N+1: `done=0`, unless another completion occurs.
- Latency is `N` cycles: 24 for `STEP=1`, 6 for `STEP=4`, 1 for `STEP=24`.
- Back-to-back: `start=1` in the cycle where `done=1` is accepted at E0+N+1.
  - `done` is a single pulse; `busy` goes high again.
  - Throughput is one result per `N+1` cycles.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ZBRITESI_FLAGS_EN`.
- **Defined:** `zero`, `negative` and `overflow` are computed and registered at completion as described above.
- **Undefined:**
  - flag logic and registers are omitted;
  - `zero`, `negative` and `overflow` are tied to 0;
  - `diff`, `borrowout`, `busy` and `done` behave the same as when the macro is defined.

## Test plan
1. `STEP=1`, `a=0x000005`, `b=0x000003`, pulse `start` -> `done` exactly 24 cycles later, `diff=0x000002`, `borrowout=0`, `zero=0`, `negative=0`, `overflow=0`.
2. `a=0x000000`, `b=0x000001` -> `diff=0xFFFFFF`, `borrowout=1`, `negative=1`, `overflow=0`. Then `a=b=0x123456` -> `diff=0`, `zero=1`, `borrowout=0`.
3. `a=0x800000`, `b=0x000001` -> `diff=0x7FFFFF`, `overflow=1`, `borrowout=0`. Then `a=0x7FFFFF`, `b=0xFFFFFF` -> `diff=0x800000`, `overflow=1`, `borrowout=1`.
4. Pulse `start` again at cycle 5 of a running operation with different operands -> ignored. Only one `done`, carrying the first result. Back-to-back `start` in the `done` cycle -> second result after N+1 cycles.
5. Drop `rst_n` at cycle 10 of an operation -> all outputs go to 0 immediately, no `done`. After release, a new `start` with `0x000010 - 0x000001` -> `0x00000F`.
6. `STEP=4` and `STEP=24` run the vectors from scenarios 1-3 -> identical results, with latency 6 and 1. Repeat with `ZBRITESI_FLAGS_EN` undefined -> flags stay 0, while `diff` and `borrowout` are unchanged.

Source files
------------

// File: rtl/zbritesi_24bit_seq_if.sv
// Handshake/operand bus for the sequential 24-bit subtractor.
// master: requester (drives start/a/b); slave: the subtractor.
interface zbritesi_24bit_seq_if #(
   parameter int WIDTH = 24
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrowout;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrowout, zero, negative, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrowout, zero, negative, overflow
   );
endinterface

// File: rtl/zbritesi_24bit_seq.sv
// zbritesi_24bit_seq: sequential a - b, STEP bits per clock through a
// registered borrow chain. Latency N = WIDTH/STEP cycles, start/busy/done.
// Optional macro ZBRITESI_FLAGS_EN: when defined, zero/negative/overflow
// are computed and registered at completion; otherwise they are tied to 0.
// WIDTH must be 24 and STEP must divide WIDTH.
module zbritesi_24bit_seq #(
   parameter int WIDTH = 24,
   parameter int STEP  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   zbritesi_24bit_seq_if.slave  bus
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;      // operand shift registers
   logic [WIDTH-1:0] res_q;         // partial result, filled from the MSB side
   logic             brw_q;         // borrow carried between slices
   logic [CW-1:0]    cnt_q;         // slice index of the current cycle
   logic             busy_q, done_q, borrow_q;
   logic [WIDTH-1:0] diff_q;

   logic [STEP:0]    slice_w;       // {borrow_out, slice}
   logic [WIDTH-1:0] res_d;
   logic             brw_d;
   logic             last_w;
   logic             accept_w;
   logic             finish_w;

   // One slice of the subtraction; the extra MSB is the borrow out.
   assign slice_w = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]}
                    - {{STEP{1'b0}}, brw_q};
   assign brw_d   = slice_w[STEP];
   // New slice enters at the top; after N shifts the first slice sits at bit 0.
   assign res_d   = WIDTH'({slice_w[STEP-1:0], res_q} >> STEP);
   assign last_w  = (cnt_q == CW'(N - 1));

   assign accept_w = (state_q == S_IDLE) && bus.start;
   assign finish_w = (state_q == S_RUN) && last_w;

   // Control FSM plus datapath registers; all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  brw_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            S_RUN: begin
               a_q   <= a_q >> STEP;
               b_q   <= b_q >> STEP;
               res_q <= res_d;
               brw_q <= brw_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_w) begin
                  diff_q   <= res_d;
                  borrow_q <= brw_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.diff      = diff_q;
   assign bus.borrowout = borrow_q;

`ifdef ZBRITESI_FLAGS_EN
   logic a_msb_q, b_msb_q;           // operand signs, lost from the shifters
   logic zero_q, neg_q, ovf_q;

   // Capture operand signs at accept, register status flags at completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept_w) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
         end
         if (finish_w) begin
            zero_q <= (res_d == '0);
            neg_q  <= res_d[WIDTH-1];
            ovf_q  <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
         end
      end
   end

   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;
   assign bus.overflow = ovf_q;
`else
   logic unused_w;
   assign unused_w     = accept_w ^ finish_w;
   assign bus.zero     = 1'b0;
   assign bus.negative = 1'b0;
   assign bus.overflow = 1'b0;
`endif

endmodule
